uart_rx_packet_parser: RTL

//  Frame decoder directly downstream of the UART receive path. Consumes o_Rx_Byte/o_Rx_Done,

---
 rtl/uart_rx_packet_parser.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_packet_parser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_rx_packet_parser: [A5][LEN][payload][CSUM] frame decoder after UART RX |
// | Optional idle timeout: define UART_PKT_TIMEOUT_EN.     Rev 1.0              |
// +----------------------------------------------------------------------------+
module uart_rx_packet_parser #(
  parameter int MAX_LEN = 16
`ifdef UART_PKT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] i_Rx_Byte,
  input  logic       i_Rx_Done,
  output logic [7:0] o_Data_Byte,
  output logic       o_Data_Valid,
  output logic [7:0] o_Pkt_Len,
  output logic       o_Pkt_Done,
  output logic       o_Pkt_Err,
  output logic [1:0] o_Err_Code,
  output logic       o_Busy
);

  localparam logic [7:0] C_SOF         = 8'hA5;
  localparam logic [7:0] C_MAX_LEN     = 8'(MAX_LEN);
  localparam logic [1:0] C_ERR_LEN     = 2'b01;
  localparam logic [1:0] C_ERR_CSUM    = 2'b10;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LEN     = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_CSUM    = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic       rx_done_dly_q;
  logic       rx_event;
  logic [7:0] sum_q, sum_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_byte_q, data_byte_d;
  logic       data_valid_q, data_valid_d;
  logic [7:0] pkt_len_q, pkt_len_d;
  logic       pkt_done_q, pkt_done_d;
  logic       pkt_err_q, pkt_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic       busy_q, busy_d;
  logic       timeout_hit;

  // Delay register resets high so a Done level present at reset release is not an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_done_dly_q <= 1'b1;
    end else begin
      rx_done_dly_q <= i_Rx_Done;
    end
  end

  assign rx_event = i_Rx_Done & ~rx_done_dly_q;

`ifdef UART_PKT_TIMEOUT_EN
  localparam logic [31:0] C_TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [31:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d  = idle_cnt_q + 32'd1;
    if ((state_q == ST_IDLE) || rx_event) begin
      idle_cnt_d = 32'd0;
    end
    // A byte arriving in the expiry cycle takes priority over the timeout.
    timeout_hit = (state_q != ST_IDLE) && !rx_event && (idle_cnt_q >= C_TIMEOUT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_q <= 32'd0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    data_byte_d  = data_byte_q;
    data_valid_d = 1'b0;
    pkt_len_d    = pkt_len_q;
    pkt_done_d   = 1'b0;
    pkt_err_d    = 1'b0;
    err_code_d   = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_event && (i_Rx_Byte == C_SOF)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (rx_event) begin
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > C_MAX_LEN)) begin
            pkt_err_d  = 1'b1;
            err_code_d = C_ERR_LEN;
            state_d    = ST_IDLE;
          end else begin
            pkt_len_d = i_Rx_Byte;
            sum_d     = i_Rx_Byte;
            cnt_d     = i_Rx_Byte;
            state_d   = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_event) begin
          data_byte_d  = i_Rx_Byte;
          data_valid_d = 1'b1;
          sum_d        = sum_q + i_Rx_Byte;
          cnt_d        = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (rx_event) begin
          if (i_Rx_Byte == sum_q) begin
            pkt_done_d = 1'b1;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = C_ERR_CSUM;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (timeout_hit) begin
      pkt_err_d  = 1'b1;
      err_code_d = C_ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sum_q   <= 8'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_byte_q  <= 8'd0;
      data_valid_q <= 1'b0;
      pkt_len_q    <= 8'd0;
      pkt_done_q   <= 1'b0;
      pkt_err_q    <= 1'b0;
      err_code_q   <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      data_byte_q  <= data_byte_d;
      data_valid_q <= data_valid_d;
      pkt_len_q    <= pkt_len_d;
      pkt_done_q   <= pkt_done_d;
      pkt_err_q    <= pkt_err_d;
      err_code_q   <= err_code_d;
      busy_q       <= busy_d;
    end
  end

  assign o_Data_Byte  = data_byte_q;
  assign o_Data_Valid = data_valid_q;
  assign o_Pkt_Len    = pkt_len_q;
  assign o_Pkt_Done   = pkt_done_q;
  assign o_Pkt_Err    = pkt_err_q;
  assign o_Err_Code   = err_code_q;
  assign o_Busy       = busy_q;

endmodule
`default_nettype wire
